// File: rtl/score_sum_unloader.sv
// Readback engine: drains PARALLEL score-sum BRAM banks, bank by bank, into a
// valid/ready stream through a 2-entry FIFO that absorbs the 1-cycle read latency.
module score_sum_unloader #(
    parameter  int ADDR_WIDTH = 13,
    parameter  int DATA_WIDTH = 32,
    parameter  int PARALLEL   = 4,
    parameter  int WORDS      = 4096,
    localparam int BANK_W     = (PARALLEL > 1) ? $clog2(PARALLEL) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            count,
    output logic [ADDR_WIDTH*PARALLEL-1:0] mem_addr_score_sum,
    output logic [PARALLEL-1:0]            mem_score_write_sum_en,
    input  logic [DATA_WIDTH*PARALLEL-1:0] mem_data_in_score_sum,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [BANK_W-1:0]              out_bank,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] WORDS_L   = (ADDR_WIDTH+1)'(WORDS);
    localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(PARALLEL - 1);

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          last_addr_q, last_addr_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [BANK_W-1:0]              bank_q, bank_d;
    logic [ADDR_WIDTH*PARALLEL-1:0] mem_addr_q, mem_addr_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic                           inflight_q;
    logic [BANK_W-1:0]              cap_bank_q;
    logic                           cap_last_q;

    logic [DATA_WIDTH-1:0]          fifo_data_q [2];
    logic [BANK_W-1:0]              fifo_bank_q [2];
    logic [1:0]                     fifo_last_q;
    logic                           rd_ptr_q, wr_ptr_q;
    logic [1:0]                     occ_q;

    logic [ADDR_WIDTH:0]            count_clip_s;
    logic                           pop_s, issue_s, is_last_s, final_issue_s;
    logic [1:0]                     occ_after_pop_s;
    logic [DATA_WIDTH-1:0]          cap_data_s;

    assign count_clip_s    = (count > WORDS_L) ? WORDS_L : count;
    assign pop_s           = out_valid & out_ready;
    assign occ_after_pop_s = occ_q - {1'b0, pop_s};
    // Counting this cycle's pop lets a read issue while one word leaves, so ready=1 streams without bubbles.
    assign issue_s         = (state_q == ST_READ) &&
                             (({1'b0, occ_after_pop_s} + {2'b00, inflight_q}) < 3'd2);
    assign is_last_s       = (bank_q == LAST_BANK) && (addr_q == last_addr_q);
    assign final_issue_s   = issue_s & is_last_s;

    // Select the returning BRAM word from the bank addressed one cycle earlier.
    always_comb begin
        cap_data_s = {DATA_WIDTH{1'b0}};
        for (int b = 0; b < PARALLEL; b++) begin
            cap_data_s = (cap_bank_q == BANK_W'(b)) ?
                         mem_data_in_score_sum[b*DATA_WIDTH +: DATA_WIDTH] : cap_data_s;
        end
    end

    // Next-state logic for the sequencer and the read address/bank counters.
    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        addr_d      = addr_q;
        bank_d      = bank_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    last_addr_d = ADDR_WIDTH'(count_clip_s - {{ADDR_WIDTH{1'b0}}, 1'b1});
                    addr_d      = {ADDR_WIDTH{1'b0}};
                    bank_d      = {BANK_W{1'b0}};
                    busy_d      = 1'b1;
                    if (count_clip_s == {(ADDR_WIDTH+1){1'b0}}) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (final_issue_s) begin
                    state_d = ST_DRAIN;
                end else if (issue_s) begin
                    if (addr_q == last_addr_q) begin
                        addr_d = {ADDR_WIDTH{1'b0}};
                        bank_d = bank_q + BANK_W'(1);
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && out_last) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                addr_d  = {ADDR_WIDTH{1'b0}};
                bank_d  = {BANK_W{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                addr_d  = {ADDR_WIDTH{1'b0}};
                bank_d  = {BANK_W{1'b0}};
            end
        endcase
    end

    // Only the active bank's slice carries the counter; all others sit at zero.
    always_comb begin
        mem_addr_d = {(ADDR_WIDTH*PARALLEL){1'b0}};
        for (int b = 0; b < PARALLEL; b++) begin
            mem_addr_d[b*ADDR_WIDTH +: ADDR_WIDTH] =
                (bank_d == BANK_W'(b)) ? addr_d : {ADDR_WIDTH{1'b0}};
        end
    end

    // Sequencer state, capture pipeline and output FIFO; rst flushes all of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_addr_q    <= {ADDR_WIDTH{1'b0}};
            addr_q         <= {ADDR_WIDTH{1'b0}};
            bank_q         <= {BANK_W{1'b0}};
            mem_addr_q     <= {(ADDR_WIDTH*PARALLEL){1'b0}};
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            inflight_q     <= 1'b0;
            cap_bank_q     <= {BANK_W{1'b0}};
            cap_last_q     <= 1'b0;
            fifo_data_q[0] <= {DATA_WIDTH{1'b0}};
            fifo_data_q[1] <= {DATA_WIDTH{1'b0}};
            fifo_bank_q[0] <= {BANK_W{1'b0}};
            fifo_bank_q[1] <= {BANK_W{1'b0}};
            fifo_last_q    <= 2'b00;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            occ_q          <= 2'd0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inflight_q  <= issue_s;
            cap_bank_q  <= bank_q;
            cap_last_q  <= is_last_s;
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= cap_data_s;
                fifo_bank_q[wr_ptr_q] <= cap_bank_q;
                fifo_last_q[wr_ptr_q] <= cap_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
        end
    end

    assign out_valid              = (occ_q != 2'd0);
    assign out_data               = fifo_data_q[rd_ptr_q];
    assign out_bank               = fifo_bank_q[rd_ptr_q];
    assign out_last               = fifo_last_q[rd_ptr_q];
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign mem_addr_score_sum     = mem_addr_q;
    assign mem_score_write_sum_en = {PARALLEL{1'b0}};

endmodule

// File: tb/tb_score_sum_unloader.sv
// Directed bench for score_sum_unloader: table of runs checked against a word-order
// scoreboard, plus hand-written reset/interrupt sequences.
module tb_score_sum_unloader;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int P  = 4;
    localparam int WORDS = 4096;
    localparam int BW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [AW:0]        count;
    logic [AW*P-1:0]    mem_addr;
    logic [P-1:0]       wen;
    logic [DW*P-1:0]    mem_data_in;
    logic [DW-1:0]      out_data;
    logic [BW-1:0]      out_bank;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;

    score_sum_unloader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLEL(P), .WORDS(WORDS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .mem_addr_score_sum(mem_addr), .mem_score_write_sum_en(wen),
        .mem_data_in_score_sum(mem_data_in),
        .out_data(out_data), .out_bank(out_bank), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Preloaded bank contents: bank b, address a holds 0x(b)000_0000 | a.
    function automatic logic [DW-1:0] word_of(input int b, input int a);
        logic [DW-1:0] w;
        w = {4'(b), 28'(a)};
        return w;
    endfunction

    // Registered-read BRAM model, one per bank.
    always @(posedge clk) begin
        for (int b = 0; b < P; b++) begin
            mem_data_in[b*DW +: DW] <= word_of(b, int'(mem_addr[b*AW +: AW]));
        end
    end

    typedef struct {
        int cnt_in;
        int cnt_eff;
        bit bp;
        int inj;
    } vec_t;

    vec_t vecs [6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int bp_mode = 2;
    int start_cyc = 0;
    int exp_eff = 0;
    int exp_total = 0;
    int acc_cnt = 0;
    bit first_seen = 1'b0;
    int first_cyc = -1;
    int last_acc_cyc = -1;
    bit done_seen = 1'b0;
    int done_cyc = -1;
    bit hold_pending = 1'b0;
    logic [DW-1:0] hold_data;
    logic [BW-1:0] hold_bank;
    logic hold_last;
    int done_hits;
    int valid_hits;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (mon_en) begin
            if (hold_pending) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(hold_data));
                check("hold_bank", 64'(out_bank), 64'(hold_bank));
                check("hold_last", 64'(out_last), 64'(hold_last));
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            hold_bank    = out_bank;
            hold_last    = out_last;
            if (cyc == start_cyc + 1) begin
                check("busy_after_start", 64'(busy), 64'd1);
            end
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                first_cyc  = cyc;
            end
            if (out_valid && out_ready) begin
                if (acc_cnt >= exp_total) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%08h expected=no word (cycle %0d)", out_data, cyc);
                end else begin
                    check("word_data", 64'(out_data), 64'(word_of(acc_cnt / exp_eff, acc_cnt % exp_eff)));
                    check("word_bank", 64'(out_bank), 64'(acc_cnt / exp_eff));
                    check("word_last", 64'(out_last), 64'(acc_cnt == exp_total - 1));
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check("busy_at_done", 64'(busy), 64'(exp_total == 0));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        if (bp_mode == 0) begin
            out_ready = 1'b1;
        end else if (bp_mode == 1) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        end
    endtask

    task automatic begin_run(input int cnt_in, input int eff, input bit bp);
        exp_eff      = eff;
        exp_total    = P * eff;
        acc_cnt      = 0;
        first_seen   = 1'b0;
        first_cyc    = -1;
        last_acc_cyc = -1;
        done_seen    = 1'b0;
        done_cyc     = -1;
        hold_pending = 1'b0;
        bp_mode      = bp ? 1 : 0;
        out_ready    = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        mon_en       = 1'b1;
        start        = 1'b1;
        count        = (AW+1)'(cnt_in);
        start_cyc    = cyc;
        tick();
        start        = 1'b0;
    endtask

    task automatic finish_run(input int inj, input bit bp);
        for (int c = 0; c < 3 * exp_total + 40 && !done_seen; c++) begin
            if (inj != 0 && cyc == start_cyc + inj) begin
                start = 1'b1;
                count = (AW+1)'(2);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done expected=done after %0d words (got %0d)", exp_total, acc_cnt);
        end else begin
            check("done_cyc", 64'(done_cyc), 64'(exp_total == 0 ? start_cyc + 1 : last_acc_cyc + 1));
            check("word_count", 64'(acc_cnt), 64'(exp_total));
            if (exp_total > 0) begin
                check("first_valid_cyc", 64'(first_cyc), 64'(start_cyc + 3));
            end else begin
                check("no_valid", 64'(first_seen), 64'd0);
            end
            if (exp_total > 0 && !bp) begin
                check("last_word_cyc", 64'(last_acc_cyc), 64'(start_cyc + 2 + exp_total));
            end
            check("busy_after_done", 64'(busy), 64'd0);
            check("done_single", 64'(done), 64'd0);
            check("addr_idle", 64'(mem_addr), 64'd0);
            check("wen_zero", 64'(wen), 64'd0);
        end
        mon_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{cnt_in: 4,    cnt_eff: 4,    bp: 1'b0, inj: 0};
        vecs[1] = '{cnt_in: 4,    cnt_eff: 4,    bp: 1'b1, inj: 0};
        vecs[2] = '{cnt_in: 0,    cnt_eff: 0,    bp: 1'b0, inj: 0};
        vecs[3] = '{cnt_in: 5000, cnt_eff: 4096, bp: 1'b0, inj: 0};
        vecs[4] = '{cnt_in: 8,    cnt_eff: 8,    bp: 1'b0, inj: 5};
        vecs[5] = '{cnt_in: 3,    cnt_eff: 3,    bp: 1'b1, inj: 0};

        rst       = 1'b1;
        start     = 1'b0;
        count     = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_bank", 64'(out_bank), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wen", 64'(wen), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            begin_run(vecs[i].cnt_in, vecs[i].cnt_eff, vecs[i].bp);
            finish_run(vecs[i].inj, vecs[i].bp);
            tick();
        end

        // Reset while stalled mid-stream, then a fresh one-word-per-bank run.
        begin_run(4, 4, 1'b0);
        for (int c = 0; c < 40 && acc_cnt < 6; c++) begin
            tick();
        end
        check("mid_words_before_rst", 64'(acc_cnt), 64'd6);
        bp_mode   = 2;
        out_ready = 1'b0;
        tick();
        tick();
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        rst       = 1'b0;
        bp_mode   = 0;
        out_ready = 1'b1;
        done_hits  = 0;
        valid_hits = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done) done_hits++;
            if (out_valid) valid_hits++;
        end
        check("mid_rst_no_done", 64'(done_hits), 64'd0);
        check("mid_rst_no_valid", 64'(valid_hits), 64'd0);
        begin_run(1, 1, 1'b0);
        finish_run(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_sum_unloader.md
# score_sum_unloader

Readback engine for the diffusion score-sum banks. After the diffusion core finishes and the PS side regains the `bram_score_sum_table` banks, this block reads all `PARALLEL` banks bank by bank and streams the words out over a valid/ready interface toward the PS/DMA path. It handles the 1-cycle BRAM read latency and output backpressure without losing or duplicating words.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: width of each bank address.
- `DATA_WIDTH`, 32: score word width.
- `PARALLEL`, 4: number of score-sum banks.
- `WORDS`, 4096: bank depth (DEPTH/2); the maximum legal `count`.

Ports (clock and reset first):
- `clk`  in  1: single clock; all logic samples on its rising edge. The same clock drives the BRAMs.
- `rst`  in  1: reset; synchronous and active-high.
- `start`  in  1: one-cycle pulse. Accepted only in IDLE.
- `count`  in  ADDR_WIDTH+1: words to read per bank. Latched on an accepted `start`.
- `mem_addr_score_sum`  out  ADDR_WIDTH*PARALLEL: packed bank addresses; bank b uses slice [b*ADDR_WIDTH +: ADDR_WIDTH].
- `mem_score_write_sum_en`  out  PARALLEL: bank write enables; constant 0.
- `mem_data_in_score_sum`  in  DATA_WIDTH*PARALLEL: packed registered BRAM read data.
- `out_data`  out  DATA_WIDTH: stream word.
- `out_bank`  out  log2(PARALLEL), minimum 1: source bank of `out_data`.
- `out_last`  out  1: marks the final word of the final bank.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: stream ready.
- `busy`  out  1: high from an accepted `start` until `done`.
- `done`  out  1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ when `start` is high and latched `count` is not 0.
  - IDLE → DONE when `start` is high and `count` is 0.
  - READ → DRAIN after the read for (bank PARALLEL-1, address count-1) is issued.
  - DRAIN → DONE when the last word is accepted (`out_valid & out_ready & out_last`).
  - DONE → IDLE unconditionally.
- Latched count: a `count` larger than `WORDS` is clipped to `WORDS`.
- Read order: bank 0 addresses 0..count-1, then bank 1, and so on up to bank PARALLEL-1.
  - Only the active bank's address slice moves.
  - Inactive slices hold 0.
- Read issue: a read is issued in a cycle only when (buffer occupancy + reads in flight) < 2.
  - The buffer is a 2-entry FIFO that captures BRAM data one cycle after issue.
  - This flow control means words are never dropped and the address never runs ahead of buffer space.
- Bank tagging: captured data is selected from the slice of the bank that was addressed on the previous cycle, tagged with that bank index, and tagged `last` if it is the final word.
- Stream output: the FIFO head drives `out_data`, `out_bank` and `out_last`.
  - Pop on `out_valid & out_ready`.
  - While `out_valid` is high and `out_ready` is low, `out_data`, `out_bank` and `out_last` are held stable.
- `start` while `busy` is ignored. The latched `count` is unchanged.
- `rst` mid-operation: the next edge returns the block to IDLE, flushes the FIFO and in-flight state, and drops `out_valid`. The interrupted transfer produces no `done`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_bank`=0, `out_last`=0, `busy`=0, `done`=0, all address slices 0, `mem_score_write_sum_en`=0.
- Address and valid timing:
  - Cycle N: `start` accepted.
  - Cycle N+1: `busy`=1 and address 0 of bank 0 is presented.
  - Cycle N+2: BRAM data appears.
  - Cycle N+3: `out_valid`=1 with word 0, because data is captured into the FIFO first.
- Throughput: with `out_ready` held at 1, one word per cycle with no bubbles, including across bank boundaries.
- Total latency with `out_ready`=1: the last word is valid at N+2+PARALLEL*count.
  - `done` pulses the cycle after the last word is accepted.
  - `busy` falls in the same cycle that `done` pulses.
- `count`=0: `busy` pulses for one cycle (N+1), `done` pulses at N+1, and no output is produced.
- Backpressure: `out_ready` low for any number of cycles stalls issue within 2 words. When ready returns, the stream resumes with the next word in order.
- A simultaneous pop and capture in the same cycle keeps FIFO occupancy unchanged.
- Address arithmetic: the address counter is ADDR_WIDTH bits wide and wraps to 0 at the bank change. The bank counter does not wrap; the FSM terminates first.

## Test plan
- Bank preload, `count`=4, `out_ready`=1:
  - Stimulus: bank b, address i preloaded with 0x(b)000_000(i).
  - Response: 16 words in order 0x0000_0000 … 0x3000_0003 on consecutive cycles from N+3; `out_bank` steps 0,0,0,0,1,…,3; `out_last` only on 0x3000_0003; `done` one cycle after the last word.
- Same preload, `out_ready` toggled 1,0,0,1 repeating:
  - Response: identical 16-word sequence with no drops or duplicates; `out_data` stable whenever valid is high and ready is low.
- `count`=0:
  - Response: `done` at N+1, `out_valid` never asserted.
- `count`=5000 with `WORDS`=4096:
  - Response: exactly 4096 words per bank, 16384 words total; the address wraps to 0 at each bank change.
- Second `start` at N+5 with `count`=2 during a run with `count`=8:
  - Response: ignored; the stream still carries 32 words.
- `rst` asserted mid-stream (after 6 words) while `out_ready`=0:
  - Response: the next edge gives `out_valid`=0, `busy`=0 and addresses 0, with no `done`.
  - A subsequent `start` with `count`=1 yields 4 words, starting from bank 0, address 0.
